// File: rtl/operand_sequencer.sv
// operand_sequencer: pulls two operands from a first-word-fall-through FIFO,
// hands them to an external adder, and pushes the adder result into an
// output FIFO. One pair is in flight at a time; the minimum pair period is
// five cycles (LOAD_A, LOAD_B, ISSUE, WAIT, ACK).
module operand_sequencer #(
  parameter int DATA_WIDTH = 32
) (
  input  logic                  clock,
  input  logic                  reset,
  // input FIFO (first-word-fall-through)
  input  logic                  in_empty,
  input  logic [DATA_WIDTH-1:0] in_dout,
  output logic                  in_rd_en,
  // adder interface
  output logic [DATA_WIDTH-1:0] addend1,
  output logic [DATA_WIDTH-1:0] addend2,
  output logic                  data_available,
  input  logic [DATA_WIDTH-1:0] sum,
  input  logic                  complete,
  output logic                  res_rd_en,
  // output FIFO
  input  logic                  out_full,
  output logic                  out_wr_en,
  output logic [DATA_WIDTH-1:0] out_din,
  // status
  output logic                  busy,
  output logic [15:0]           pair_count
);

  typedef enum logic [2:0] {
    LOAD_A = 3'd0,
    LOAD_B = 3'd1,
    ISSUE  = 3'd2,
    WAIT   = 3'd3,
    ACK    = 3'd4
  } state_t;

  state_t                r_state;
  state_t                w_state_next;
  logic [DATA_WIDTH-1:0] r_addend1;
  logic [DATA_WIDTH-1:0] r_addend2;
  logic [15:0]           r_pair_count;

  logic                  w_load_a;
  logic                  w_load_b;
  logic                  w_issue;
  logic                  w_retire;
  logic                  w_busy;

  // State register; an asynchronous reset drops any half-loaded or
  // in-flight pair and restarts the fetch from LOAD_A.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      r_state <= LOAD_A;
    end else begin
      r_state <= w_state_next;
    end
  end

  // Next-state and strobe decode; every strobe is a pure function of the
  // current state and the FIFO/adder handshake inputs.
  always_comb begin
    w_state_next = r_state;
    w_load_a     = 1'b0;
    w_load_b     = 1'b0;
    w_issue      = 1'b0;
    w_retire     = 1'b0;
    w_busy       = 1'b1;
    case (r_state)
      LOAD_A: begin
        w_busy = 1'b0;
        if (!in_empty) begin
          w_load_a     = 1'b1;
          w_state_next = LOAD_B;
        end
      end
      LOAD_B: begin
        if (!in_empty) begin
          w_load_b     = 1'b1;
          w_state_next = ISSUE;
        end
      end
      ISSUE: begin
        w_issue      = 1'b1;
        w_state_next = WAIT;
      end
      WAIT: begin
        // The result stays in the adder until the output FIFO has room;
        // the write and the adder acknowledge happen in the same cycle.
        if (complete && !out_full) begin
          w_retire     = 1'b1;
          w_state_next = ACK;
        end
      end
      ACK: begin
        // One quiet cycle so the adder can drop complete before the next pair.
        w_state_next = LOAD_A;
      end
      default: begin
        w_state_next = LOAD_A;
      end
    endcase
  end

  // Operand registers; each captures the FIFO head on its pop cycle.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      r_addend1 <= '0;
      r_addend2 <= '0;
    end else begin
      if (w_load_a) begin
        r_addend1 <= in_dout;
      end
      if (w_load_b) begin
        r_addend2 <= in_dout;
      end
    end
  end

  // Count of results pushed to the output FIFO; wraps silently at 16 bits.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      r_pair_count <= 16'h0000;
    end else if (w_retire) begin
      r_pair_count <= r_pair_count + 16'h0001;
    end
  end

  assign in_rd_en       = w_load_a | w_load_b;
  assign addend1        = r_addend1;
  assign addend2        = r_addend2;
  assign data_available = w_issue;
  assign res_rd_en      = w_retire;
  assign out_wr_en      = w_retire;
  assign out_din        = sum;
  assign busy           = w_busy;
  assign pair_count     = r_pair_count;

endmodule
